// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage.
// Latency: n/a (package). Backpressure: n/a.
// Contents: opcode constants, instruction-format enum, decoded-entry struct.
package decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // The entry always carries a 64-bit sign-extended immediate so one struct
    // serves both XLEN=32 and XLEN=64; the top truncates, which keeps the sign.
    localparam int IMM_MAX_W = 64;
    localparam int RA_W      = 5;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_t;

    typedef struct packed {
        fmt_t                   fmt;
        logic [RA_W-1:0]        rs1;
        logic [RA_W-1:0]        rs2;
        logic [RA_W-1:0]        rd;
        logic [IMM_MAX_W-1:0]   imm;
        logic                   illegal;
    } dec_entry_t;

    function automatic logic [IMM_MAX_W-1:0] sext32(input logic [31:0] v);
        return {{(IMM_MAX_W-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder: raw word -> format, register fields, immediate.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: in_instr (32-bit raw word) -> out_dec (dec_entry_t).
module instr_decoder
    import decode_pkg::*;
(
    input  logic [31:0] in_instr,
    output dec_entry_t  out_dec
);

    logic [31:0] w_imm32;

    always_comb begin
        out_dec         = '0;
        out_dec.fmt     = FMT_ILL;
        out_dec.illegal = 1'b1;
        w_imm32         = '0;

        // Compressed / non-32-bit encodings fall through as illegal.
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:0])
                OPC_OP: begin
                    out_dec.fmt     = FMT_R;
                    out_dec.illegal = 1'b0;
                    out_dec.rs1     = in_instr[19:15];
                    out_dec.rs2     = in_instr[24:20];
                    out_dec.rd      = in_instr[11:7];
                end
                OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                    out_dec.fmt     = FMT_I;
                    out_dec.illegal = 1'b0;
                    out_dec.rs1     = in_instr[19:15];
                    out_dec.rd      = in_instr[11:7];
                    w_imm32         = {{20{in_instr[31]}}, in_instr[31:20]};
                end
                OPC_STORE: begin
                    out_dec.fmt     = FMT_S;
                    out_dec.illegal = 1'b0;
                    out_dec.rs1     = in_instr[19:15];
                    out_dec.rs2     = in_instr[24:20];
                    w_imm32         = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end
                OPC_BRANCH: begin
                    out_dec.fmt     = FMT_B;
                    out_dec.illegal = 1'b0;
                    out_dec.rs1     = in_instr[19:15];
                    out_dec.rs2     = in_instr[24:20];
                    w_imm32         = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                       in_instr[30:25], in_instr[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    out_dec.fmt     = FMT_U;
                    out_dec.illegal = 1'b0;
                    out_dec.rd      = in_instr[11:7];
                    w_imm32         = {in_instr[31:12], 12'b0};
                end
                OPC_JAL: begin
                    out_dec.fmt     = FMT_J;
                    out_dec.illegal = 1'b0;
                    out_dec.rd      = in_instr[11:7];
                    w_imm32         = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                       in_instr[20], in_instr[30:21], 1'b0};
                end
                default: begin
                    out_dec.fmt     = FMT_ILL;
                    out_dec.illegal = 1'b1;
                end
            endcase
        end

        out_dec.imm = sext32(w_imm32);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer and illegal counter.
// Latency: 1 cycle from accept to out_valid; sustains 1 instr/cycle.
// Backpressure: in_ready = !entry1_valid, registered (no path from out_ready).
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_instr from fetch;
//        flush kills buffered entries; out_valid/out_ready plus decoded fields
//        (out_fmt, out_rs1, out_rs2, out_rd, out_imm, out_illegal); illegal_cnt.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_fmt,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    dec_entry_t         w_dec;
    dec_entry_t         r_e0;
    dec_entry_t         r_e1;
    logic               r_v0;
    logic               r_v1;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_acc;
    logic               w_drain;

    instr_decoder u_dec (
        .in_instr (in_instr),
        .out_dec  (w_dec)
    );

    // Flush outranks both handshakes: a flushed cycle neither accepts nor drains.
    assign w_acc   = in_valid & ~r_v1 & ~flush;
    assign w_drain = r_v0 & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0  <= 1'b0;
            r_v1  <= 1'b0;
            r_e0  <= '0;
            r_e1  <= '0;
            r_cnt <= '0;
        end else begin
            if (flush) begin
                r_v0 <= 1'b0;
                r_v1 <= 1'b0;
            end else if (w_drain) begin
                // Entry 0 leaves; refill from the overflow entry first, else
                // from the incoming word. Accept cannot coincide with r_v1.
                if (r_v1) begin
                    r_e0 <= r_e1;
                    r_v1 <= 1'b0;
                end else if (w_acc) begin
                    r_e0 <= w_dec;
                end else begin
                    r_v0 <= 1'b0;
                end
            end else if (w_acc) begin
                if (!r_v0) begin
                    r_e0 <= w_dec;
                    r_v0 <= 1'b1;
                end else begin
                    r_e1 <= w_dec;
                    r_v1 <= 1'b1;
                end
            end

            if (w_acc && w_dec.illegal && !(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready    = ~r_v1;
    assign out_valid   = r_v0;
    assign out_fmt     = r_e0.fmt;
    assign out_rs1     = REG_AW'(r_e0.rs1);
    assign out_rs2     = REG_AW'(r_e0.rs2);
    assign out_rd      = REG_AW'(r_e0.rd);
    assign out_imm     = r_e0.imm[XLEN-1:0];
    assign out_illegal = r_e0.illegal;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [2:0]  out_fmt;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm;
    logic [7:0]  illegal_cnt;

    logic        in_ready2, out_valid2, out_illegal2;
    logic [2:0]  out_fmt2;
    logic [4:0]  out_rs12, out_rs22, out_rd2;
    logic [31:0] out_imm2;
    logic [1:0]  illegal_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .REG_AW(5), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_fmt(out_fmt), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    // Second instance, same stimulus, narrow counter to observe saturation.
    decode_stage #(.XLEN(32), .REG_AW(5), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .out_fmt(out_fmt2), .out_rs1(out_rs12), .out_rs2(out_rs22), .out_rd(out_rd2),
        .out_imm(out_imm2), .out_illegal(out_illegal2), .illegal_cnt(illegal_cnt2)
    );

    typedef struct {
        int          fmt;
        int          rs1;
        int          rs2;
        int          rd;
        logic [31:0] imm;
        bit          ill;
    } exp_t;

    exp_t q[$];
    int   m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder written from the format rules with plain arithmetic.
    function automatic exp_t model(input logic [31:0] w);
        exp_t   e;
        longint lw;
        longint v;
        int     op;
        int     f_rd, f_rs1, f_rs2;
        e  = '{fmt: 7, rs1: 0, rs2: 0, rd: 0, imm: 32'd0, ill: 1'b1};
        lw = longint'(w);
        if (lw % 4 != 3) return e;
        op    = int'(lw % 128);
        f_rd  = int'((lw / 128) % 32);
        f_rs1 = int'((lw / 32768) % 32);
        f_rs2 = int'((lw / 1048576) % 32);
        v     = 0;
        case (op)
            51: begin
                e.fmt = 0; e.rs1 = f_rs1; e.rs2 = f_rs2; e.rd = f_rd;
            end
            19, 3, 103: begin
                e.fmt = 1; e.rs1 = f_rs1; e.rd = f_rd;
                v = lw / 1048576;
                if (v >= 2048) v -= 4096;
            end
            35: begin
                e.fmt = 2; e.rs1 = f_rs1; e.rs2 = f_rs2;
                v = (lw / 33554432) * 32 + (lw / 128) % 32;
                if (v >= 2048) v -= 4096;
            end
            99: begin
                e.fmt = 3; e.rs1 = f_rs1; e.rs2 = f_rs2;
                v = ((lw >> 31) % 2) * 4096 + ((lw >> 7) % 2) * 2048
                  + ((lw >> 25) % 64) * 32 + ((lw >> 8) % 16) * 2;
                if (v >= 4096) v -= 8192;
            end
            55, 23: begin
                e.fmt = 4; e.rd = f_rd;
                v = (lw / 4096) * 4096;
            end
            111: begin
                e.fmt = 5; e.rd = f_rd;
                v = ((lw >> 31) % 2) * 1048576 + ((lw >> 12) % 256) * 4096
                  + ((lw >> 20) % 2) * 2048 + ((lw >> 21) % 1024) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            default: return e;
        endcase
        e.ill = 1'b0;
        e.imm = v[31:0];
        return e;
    endfunction

    // Monitor / scoreboard: all DUT signals are stable at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        int   sat;
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_illegal_cnt", illegal_cnt, 0);
        end else begin
            sat = (m_cnt > 3) ? 3 : m_cnt;
            chk("in_ready", in_ready, (q.size() < 2) ? 1 : 0);
            chk("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
            chk("illegal_cnt", illegal_cnt, m_cnt);
            chk("illegal_cnt_sat2", illegal_cnt2, sat);
            if (out_valid && q.size() > 0) begin
                e = q[0];
                chk("out_fmt", out_fmt, e.fmt);
                chk("out_rs1", out_rs1, e.rs1);
                chk("out_rs2", out_rs2, e.rs2);
                chk("out_rd", out_rd, e.rd);
                chk("out_imm", out_imm, e.imm);
                chk("out_illegal", out_illegal, e.ill);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
                if (in_valid && in_ready) begin
                    e = model(in_instr);
                    q.push_back(e);
                    if (e.ill && m_cnt < 255) m_cnt++;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int g;
        bit acc;
        in_valid = 1'b1;
        in_instr = w;
        g = 0;
        do begin
            acc = in_ready;
            cycle();
            g++;
        end while (!acc && g < 200);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    logic [31:0] d_instr [5] = '{32'hFFF08293, 32'h0021A423, 32'hFE000EE3, 32'h123450B7, 32'h001000EF};
    logic [2:0]  d_fmt   [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [4:0]  d_rs1   [5] = '{5'd1, 5'd3, 5'd0, 5'd0, 5'd0};
    logic [4:0]  d_rs2   [5] = '{5'd0, 5'd2, 5'd0, 5'd0, 5'd0};
    logic [4:0]  d_rd    [5] = '{5'd5, 5'd0, 5'd0, 5'd1, 5'd1};
    logic [31:0] d_imm   [5] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};
    logic [6:0]  opcs    [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    initial begin
        logic [31:0] r;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
        #12;
        chk("reset_fmt", out_fmt, 0);
        chk("reset_rs1", out_rs1, 0);
        chk("reset_rs2", out_rs2, 0);
        chk("reset_rd", out_rd, 0);
        chk("reset_imm", out_imm, 0);
        chk("reset_illegal", out_illegal, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();

        // Directed per-format decode, one cycle latency.
        for (int i = 0; i < 5; i++) begin
            send(d_instr[i]);
            in_valid = 1'b0;
            chk("dir_valid", out_valid, 1);
            chk("dir_fmt", out_fmt, d_fmt[i]);
            chk("dir_rs1", out_rs1, d_rs1[i]);
            chk("dir_rs2", out_rs2, d_rs2[i]);
            chk("dir_rd", out_rd, d_rd[i]);
            chk("dir_imm", out_imm, d_imm[i]);
            cycle();
        end

        // Stream of 4 with downstream stalled for 3 cycles.
        out_ready = 1'b0;
        fork
            begin
                send(32'h00208033);
                send(32'h00310093);
                send(32'h0041A023);
                send(32'h00528463);
                in_valid = 1'b0;
            end
            begin
                repeat (2) cycle();
                chk("stall_in_ready_low", in_ready, 0);
                chk("stall_head_rd", out_rd, 0);
                cycle();
                out_ready = 1'b1;
            end
        join
        repeat (4) cycle();

        // Illegal encodings and counter saturation.
        send(32'hFFFFFFFF);
        in_valid = 1'b0;
        chk("ill_fmt", out_fmt, 7);
        chk("ill_flag", out_illegal, 1);
        chk("ill_imm", out_imm, 0);
        send(32'h00000000);
        in_valid = 1'b0;
        chk("ill_cnt2", illegal_cnt, 2);
        send(32'h00000001);
        send(32'h0000007B);
        send(32'h12345602);
        in_valid = 1'b0;
        chk("ill_cnt5", illegal_cnt, 5);
        chk("ill_cnt_sat", illegal_cnt2, 3);
        repeat (2) cycle();

        // Flush with both entries full and a same-cycle input.
        out_ready = 1'b0;
        send(32'h00100093);
        send(32'h00200113);
        in_valid = 1'b1; in_instr = 32'h00300193; flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) cycle();

        // Async reset while stalled.
        out_ready = 1'b0;
        send(32'h00400213);
        send(32'hFFFFFFFF);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_cnt", illegal_cnt, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cycle();

        // Randomized traffic with random backpressure and occasional flush.
        for (int c = 0; c < 600; c++) begin
            r = $urandom;
            if ($urandom_range(0, 7) == 0) in_instr = r;
            else in_instr = {r[31:7], opcs[$urandom_range(0, 8)]};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            cycle();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) cycle();
        chk("final_drained", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        bad++;
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked RV32I instruction-decode stage. It extracts register addresses and the sign-extended immediate for every base format (R/I/S/B/U/J) and classifies the format.
- Sits between fetch and register-file read. It replaces the single-format combinational I-type decoder.
- A 2-entry skid buffer decouples fetch from downstream stalls at full throughput.
- A saturating illegal-instruction counter supports debug.

Parameters:
- XLEN, 32, immediate output width (32 or 64); immediates are sign-extended to XLEN.
- REG_AW, 5, register address width (fixed encoding fields; values other than 5 are unsupported).
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction word
- flush  in  1  synchronous kill of all buffered entries
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts
- out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=ILL
- out_rs1  out  REG_AW  source 1; 0 when the format has no rs1
- out_rs2  out  REG_AW  source 2; 0 when the format has no rs2
- out_rd  out  REG_AW  destination; 0 when the format has no rd
- out_imm  out  XLEN  sign-extended immediate; 0 for R and ILL
- out_illegal  out  1  entry is an unrecognised encoding
- illegal_cnt  out  CNT_W  count of illegal instructions accepted, saturating

Behaviour:
- Reset (rst_n=0, async): both buffer entries are invalid.
  - out_valid=0, in_ready=1, illegal_cnt=0.
  - All out_* data fields are 0 and out_fmt=0.
- Decode is combinational on in_instr. The result is captured on acceptance (in_valid & in_ready). Latency is 1 cycle to out_valid.
- Opcode map:
  - 0110011 = R.
  - 0010011, 0000011, 1100111 = I.
  - 0100011 = S.
  - 1100011 = B.
  - 0110111, 0010111 = U.
  - 1101111 = J.
  - Any other opcode, or in_instr[1:0]!=2'b11, = ILL.
- Immediates:
  - I: sext(i[31:20]).
  - S: sext({i[31:25],i[11:7]}).
  - B: sext({i[31],i[7],i[30:25],i[11:8],1'b0}).
  - U: sext({i[31:12],12'b0}).
  - J: sext({i[31],i[19:12],i[20],i[30:21],1'b0}).
- Register fields: rs1=i[19:15] for R/I/S/B; rs2=i[24:20] for R/S/B; rd=i[11:7] for R/I/U/J. All other cases are 0.
- ILL entries: fmt=7, out_illegal=1, all regs and imm are 0. The entry still flows through the handshake.
- Skid buffer:
  - Entry 0 drives the outputs; entry 1 is the overflow entry.
  - in_ready = !entry1_valid, registered with no combinational path from out_ready.
  - Simultaneous accept and drain while entry 0 is valid sustains 1 instruction/cycle.
  - When out_valid & !out_ready & in accept, the new instruction goes to entry 1 and in_ready drops next cycle.
  - On drain with entry 1 valid, entry 1 moves to entry 0 in the same cycle.
- Output fields hold stable while out_valid & !out_ready.
- Flush:
  - Both entries are invalidated next edge; in_ready=1 the following cycle.
  - A same-cycle in_valid is dropped and not counted.
  - Flush has priority over accept and drain.
  - illegal_cnt is not cleared by flush.
- illegal_cnt increments once per accepted ILL instruction and saturates at 2^CNT_W-1.
- Async reset mid-transfer discards all entries immediately.

Decomposition:
- Shared package decode_pkg:
  - Opcode constants (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL).
  - fmt_t enum (FMT_R..FMT_ILL).
  - Packed dec_entry_t struct (fmt, rs1, rs2, rd, imm, illegal).
- One combinational sub-module, instr_decoder (in_instr -> dec_entry_t). The skid buffer, flush logic and counter stay in decode_stage.

Test Plan:
- Reset, then addi x5,x1,-1 (0xFFF08293) with out_ready=1 -> next cycle out_valid=1, fmt=1, rs1=1, rd=5, rs2=0, imm=0xFFFFFFFF.
- sw x2,8(x3) (0x0021A423) -> fmt=2, rs1=3, rs2=2, rd=0, imm=0x00000008.
- beq x0,x0,-4 (0xFE000EE3) -> fmt=3, imm=0xFFFFFFFC; lui x1,0x12345 (0x123450B7) -> fmt=4, rd=1, imm=0x12345000; jal x1,2048 (0x001000EF) -> fmt=5, rd=1, imm=0x00000800.
- Back-to-back stream of 4 instructions with out_ready low for 3 cycles -> in_ready drops after 2 accepts. No loss or duplication, order preserved, outputs stable while stalled, then 1/cycle on release.
- 0xFFFFFFFF and 0x00000000 accepted -> both fmt=7, out_illegal=1, imm=0, illegal_cnt=2. With CNT_W=2, 5 illegal instructions -> illegal_cnt saturates at 3.
- Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1, dropped instruction never emitted. rst_n pulsed low mid-stall -> out_valid=0 asynchronously.
